// File: rtl/pot_cook_timer.sv
// pot_cook_timer: cooking/fire stage for the pot cells of the 8x13 play grid.
// On each cook step it walks every cell in row-major order. Raw pots move to
// cooked and then to on fire, counting down the per-cell timer as they go.
// Each changed cell is sent back to the grid owner as one write over a
// valid/ready port. Cells already on fire are counted in the scan's fire
// counter.
module pot_cook_timer #(
  parameter int FRAMES_PER_STEP = 30,
  parameter int COOK_STEPS      = 10,
  parameter int BURN_STEPS      = 8
) (
  input  logic                   clk_in,
  input  logic                   reset_n,
  input  logic                   frame_tick,
  input  logic [2:0]             game_state,
  input  logic [7:0][12:0][3:0]  object_grid,
  input  logic [7:0][12:0][3:0]  time_grid,
  output logic                   wr_valid,
  input  logic                   wr_ready,
  output logic [2:0]             wr_row,
  output logic [3:0]             wr_col,
  output logic [3:0]             wr_obj,
  output logic [3:0]             wr_time,
  output logic [3:0]             fire_count,
  output logic                   scan_overrun
);

  // Game state encodings
  localparam logic [2:0] GS_PLAY  = 3'd2;
  localparam logic [2:0] GS_PAUSE = 3'd3;

  // Cell object codes handled by this stage
  localparam logic [3:0] POT_RAW    = 4'd6;
  localparam logic [3:0] POT_COOKED = 4'd7;
  localparam logic [3:0] POT_FIRE   = 4'd8;

  // Timer value of a cell that has never been armed
  localparam logic [3:0] T_UNARMED = 4'hF;

  localparam logic [7:0] STEP_LAST = 8'(FRAMES_PER_STEP - 1);
  localparam logic [3:0] COOK_T    = 4'(COOK_STEPS);
  localparam logic [3:0] BURN_T    = 4'(BURN_STEPS);
  localparam logic [2:0] LAST_ROW  = 3'd7;
  localparam logic [3:0] LAST_COL  = 4'd12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_EVAL,
    ST_WRITE,
    ST_DONE
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  presc_reg, presc_next;
  logic [2:0]  row_reg, row_next;
  logic [3:0]  col_reg, col_next;
  logic [3:0]  fire_acc_reg, fire_acc_next;
  logic [3:0]  fire_count_reg, fire_count_next;
  logic        overrun_reg, overrun_next;
  logic        wr_valid_reg, wr_valid_next;
  logic [2:0]  wr_row_reg, wr_row_next;
  logic [3:0]  wr_col_reg, wr_col_next;
  logic [3:0]  wr_obj_reg, wr_obj_next;
  logic [3:0]  wr_time_reg, wr_time_next;

  logic        in_play;
  logic        cook_step;
  logic        last_cell;
  logic [2:0]  row_adv;
  logic [3:0]  col_adv;
  logic [3:0]  fire_acc_inc;

  logic [7:0][3:0] row_cell_obj;
  logic [7:0][3:0] row_cell_time;
  logic [3:0]  cell_obj;
  logic [3:0]  cell_time;

  logic        eval_write;
  logic        eval_fire;
  logic [3:0]  eval_obj;
  logic [3:0]  eval_time;

  assign in_play = (game_state == GS_PLAY);

  // Pick the current column out of every row, then the current row out of that
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_row_sel
      assign row_cell_obj[gi]  = object_grid[gi][col_reg];
      assign row_cell_time[gi] = time_grid[gi][col_reg];
    end
  endgenerate

  assign cell_obj  = row_cell_obj[row_reg];
  assign cell_time = row_cell_time[row_reg];

  // Row-major walk: the column wraps 12->0 and carries into the row
  assign last_cell    = (row_reg == LAST_ROW) && (col_reg == LAST_COL);
  assign col_adv      = (col_reg == LAST_COL) ? 4'd0 : col_reg + 4'd1;
  assign row_adv      = (col_reg == LAST_COL) ? row_reg + 3'd1 : row_reg;
  assign fire_acc_inc = (fire_acc_reg == 4'hF) ? 4'hF : fire_acc_reg + 4'd1;

  // Frame prescaler: counts ticks in PLAY, holds in PAUSE, clears otherwise
  always_comb begin
    presc_next = presc_reg;
    cook_step  = 1'b0;
    if (in_play) begin
      if (frame_tick) begin
        if (presc_reg == STEP_LAST) begin
          presc_next = '0;
          cook_step  = 1'b1;
        end else begin
          presc_next = presc_reg + 8'd1;
        end
      end
    end else if (game_state != GS_PAUSE) begin
      presc_next = '0;
    end
  end

  // Cooking rule for the cell under the scan pointer
  always_comb begin
    eval_write = 1'b0;
    eval_fire  = 1'b0;
    eval_obj   = cell_obj;
    eval_time  = cell_time;
    case (cell_obj)
      POT_RAW: begin
        eval_write = 1'b1;
        if (cell_time == T_UNARMED) begin
          eval_time = COOK_T;
        end else if (cell_time == 4'd0) begin
          eval_obj  = POT_COOKED;
          eval_time = BURN_T;
        end else begin
          eval_time = cell_time - 4'd1;
        end
      end
      POT_COOKED: begin
        eval_write = 1'b1;
        if (cell_time == T_UNARMED) begin
          eval_time = BURN_T;
        end else if (cell_time == 4'd0) begin
          eval_obj  = POT_FIRE;
          eval_time = T_UNARMED;
        end else begin
          eval_time = cell_time - 4'd1;
        end
      end
      POT_FIRE: begin
        eval_fire = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Scan FSM next-state and write-port outputs
  always_comb begin
    state_next      = state_reg;
    row_next        = row_reg;
    col_next        = col_reg;
    fire_acc_next   = fire_acc_reg;
    fire_count_next = fire_count_reg;
    wr_valid_next   = wr_valid_reg;
    wr_row_next     = wr_row_reg;
    wr_col_next     = wr_col_reg;
    wr_obj_next     = wr_obj_reg;
    wr_time_next    = wr_time_reg;
    // A step that lands while a scan is still busy is dropped and flagged
    overrun_next    = overrun_reg | (cook_step && (state_reg != ST_IDLE));

    case (state_reg)
      ST_IDLE: begin
        if (cook_step) begin
          state_next = ST_SCAN;
        end
      end

      ST_SCAN: begin
        row_next      = 3'd0;
        col_next      = 4'd0;
        fire_acc_next = 4'd0;
        state_next    = in_play ? ST_EVAL : ST_IDLE;
      end

      ST_EVAL: begin
        if (!in_play) begin
          // Left PLAY: remaining cells stay untouched, fire_count keeps old value
          state_next = ST_IDLE;
        end else if (eval_write) begin
          wr_valid_next = 1'b1;
          wr_row_next   = row_reg;
          wr_col_next   = col_reg;
          wr_obj_next   = eval_obj;
          wr_time_next  = eval_time;
          state_next    = ST_WRITE;
        end else begin
          if (eval_fire) begin
            fire_acc_next = fire_acc_inc;
          end
          if (last_cell) begin
            state_next = ST_DONE;
          end else begin
            row_next = row_adv;
            col_next = col_adv;
          end
        end
      end

      ST_WRITE: begin
        // Request is held unchanged until it is accepted
        if (wr_ready) begin
          wr_valid_next = 1'b0;
          if (!in_play) begin
            state_next = ST_IDLE;
          end else if (last_cell) begin
            state_next = ST_DONE;
          end else begin
            row_next   = row_adv;
            col_next   = col_adv;
            state_next = ST_EVAL;
          end
        end
      end

      ST_DONE: begin
        fire_count_next = fire_acc_reg;
        fire_acc_next   = 4'd0;
        state_next      = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, prescaler and output registers
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      presc_reg      <= '0;
      row_reg        <= '0;
      col_reg        <= '0;
      fire_acc_reg   <= '0;
      fire_count_reg <= '0;
      overrun_reg    <= 1'b0;
      wr_valid_reg   <= 1'b0;
      wr_row_reg     <= '0;
      wr_col_reg     <= '0;
      wr_obj_reg     <= '0;
      wr_time_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      presc_reg      <= presc_next;
      row_reg        <= row_next;
      col_reg        <= col_next;
      fire_acc_reg   <= fire_acc_next;
      fire_count_reg <= fire_count_next;
      overrun_reg    <= overrun_next;
      wr_valid_reg   <= wr_valid_next;
      wr_row_reg     <= wr_row_next;
      wr_col_reg     <= wr_col_next;
      wr_obj_reg     <= wr_obj_next;
      wr_time_reg    <= wr_time_next;
    end
  end

  assign wr_valid     = wr_valid_reg;
  assign wr_row       = wr_row_reg;
  assign wr_col       = wr_col_reg;
  assign wr_obj       = wr_obj_reg;
  assign wr_time      = wr_time_reg;
  assign fire_count   = fire_count_reg;
  assign scan_overrun = overrun_reg;

endmodule
